// File: rtl/rgb_pixel_merger.sv
// Realigns per-channel R/G/B sample streams through per-channel FIFOs into 24-bit pixels with row/col position.
// Latency: a sample pushed on edge N reaches pix_valid_o after edge N+1; the output register holds until pix_ready_i.
module rgb_merger_fifo #(
    parameter int W  = 10,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdat_i,
    output logic [W-1:0] rdat_o,
    output logic         empty_o,
    output logic         full_o
);
    logic [W-1:0] mem_q [2**AW];
    logic [AW:0]  wr_ptr_q, rd_ptr_q;
    logic         wr_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rdat_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdat_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
endmodule

module rgb_pixel_merger #(
    parameter int DW = 8,
    parameter int AW = 4,
    parameter int CW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      valid_i,
    input  logic [2:0]      nr_i,
    input  logic [2:0]      done_i,
    input  logic [DW-1:0]   r_i,
    input  logic [DW-1:0]   g_i,
    input  logic [DW-1:0]   b_i,
    output logic            pix_valid_o,
    input  logic            pix_ready_i,
    output logic [3*DW-1:0] pix_rgb_o,
    output logic            pix_eol_o,
    output logic [CW-1:0]   pix_col_o,
    output logic [CW-1:0]   pix_row_o,
    output logic            row_end_o,
    output logic            frame_done_o,
    output logic            err_ovf_o,
    output logic            err_sync_o
);
    localparam int EW = DW + 2;

    logic [DW-1:0] ch_in [3];
    logic [EW-1:0] wdat [3];
    logic [EW-1:0] rdat [3];
    logic [2:0]    push_req, empty, full, h_pix, h_eol;
    logic          pop;

    assign ch_in[0] = r_i;
    assign ch_in[1] = g_i;
    assign ch_in[2] = b_i;

    // Entry layout {pix, eol, data}; a stand-alone NR becomes a marker entry.
    for (genvar i = 0; i < 3; i++) begin : g_ch
        assign push_req[i] = valid_i[i] | nr_i[i];
        assign wdat[i]     = valid_i[i] ? {1'b1, nr_i[i], ch_in[i]} : {1'b0, 1'b1, {DW{1'b0}}};
        assign h_pix[i]    = rdat[i][EW-1];
        assign h_eol[i]    = rdat[i][EW-2];

        rgb_merger_fifo #(.W(EW), .AW(AW)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push_req[i]),
            .pop_i   (pop),
            .wdat_i  (wdat[i]),
            .rdat_o  (rdat[i]),
            .empty_o (empty[i]),
            .full_o  (full[i])
        );
    end

    logic            pix_valid_q, pix_valid_d;
    logic [3*DW-1:0] pix_rgb_q, pix_rgb_d;
    logic            pix_eol_q, pix_eol_d;
    logic [CW-1:0]   pix_col_q, pix_col_d, pix_row_q, pix_row_d;
    logic [CW-1:0]   col_q, col_d, row_q, row_d;
    logic            row_end_q, row_end_d;
    logic [2:0]      done_seen_q, done_seen_d;
    logic            frame_done_q, frame_done_d;
    logic            err_ovf_q, err_ovf_d, err_sync_q, err_sync_d;
    logic            all_ne, all_pix, slot_free, eol_agree;

    assign all_ne    = ~|empty;
    assign all_pix   = &h_pix;
    assign slot_free = ~pix_valid_q | pix_ready_i;
    assign eol_agree = (h_eol == 3'b000) || (h_eol == 3'b111);
    // Markers never need the output slot, so they drain even under backpressure.
    assign pop       = all_ne && ((all_pix && slot_free) || !all_pix);

    always_comb begin
        pix_valid_d  = pix_valid_q & ~pix_ready_i;
        pix_rgb_d    = pix_rgb_q;
        pix_eol_d    = pix_eol_q;
        pix_col_d    = pix_col_q;
        pix_row_d    = pix_row_q;
        col_d        = col_q;
        row_d        = row_q;
        row_end_d    = 1'b0;
        err_sync_d   = err_sync_q;
        err_ovf_d    = err_ovf_q | (|(push_req & full & {3{~pop}}));
        done_seen_d  = done_seen_q | done_i;
        frame_done_d = frame_done_q |
                       ((done_seen_q == 3'b111) && !all_ne && (&empty) && !pix_valid_q);
        if (pop) begin
            if (all_pix) begin
                pix_valid_d = 1'b1;
                pix_rgb_d   = {rdat[0][DW-1:0], rdat[1][DW-1:0], rdat[2][DW-1:0]};
                pix_eol_d   = eol_agree & h_eol[0];
                pix_col_d   = col_q;
                pix_row_d   = row_q;
                if (eol_agree && h_eol[0]) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                if (!eol_agree) err_sync_d = 1'b1;
            end else if (h_pix == 3'b000) begin
                row_end_d = 1'b1;
                col_d     = '0;
                row_d     = row_q + 1'b1;
            end else begin
                err_sync_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid_q  <= 1'b0;
            pix_rgb_q    <= '0;
            pix_eol_q    <= 1'b0;
            pix_col_q    <= '0;
            pix_row_q    <= '0;
            col_q        <= '0;
            row_q        <= '0;
            row_end_q    <= 1'b0;
            done_seen_q  <= '0;
            frame_done_q <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_sync_q   <= 1'b0;
        end else begin
            pix_valid_q  <= pix_valid_d;
            pix_rgb_q    <= pix_rgb_d;
            pix_eol_q    <= pix_eol_d;
            pix_col_q    <= pix_col_d;
            pix_row_q    <= pix_row_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row_end_q    <= row_end_d;
            done_seen_q  <= done_seen_d;
            frame_done_q <= frame_done_d;
            err_ovf_q    <= err_ovf_d;
            err_sync_q   <= err_sync_d;
        end
    end

    assign pix_valid_o  = pix_valid_q;
    assign pix_rgb_o    = pix_rgb_q;
    assign pix_eol_o    = pix_eol_q;
    assign pix_col_o    = pix_col_q;
    assign pix_row_o    = pix_row_q;
    assign row_end_o    = row_end_q;
    assign frame_done_o = frame_done_q;
    assign err_ovf_o    = err_ovf_q;
    assign err_sync_o   = err_sync_q;
endmodule

// File: tb/tb_rgb_pixel_merger.sv
// Scoreboard bench for rgb_pixel_merger: expected pixels queued at drive time, compared on accept.
module tb_rgb_pixel_merger;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  valid_i, nr_i, done_i;
    logic [7:0]  r_i, g_i, b_i;
    logic        pix_valid_o, pix_ready_i;
    logic [23:0] pix_rgb_o;
    logic        pix_eol_o;
    logic [11:0] pix_col_o, pix_row_o;
    logic        row_end_o, frame_done_o, err_ovf_o, err_sync_o;

    int checks = 0;
    int failures = 0;
    int re_cnt = 0;
    int mcol = 0;
    int mrow = 0;
    logic [48:0] sbq [$];

    rgb_pixel_merger #(.DW(8), .AW(4), .CW(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .nr_i         (nr_i),
        .done_i       (done_i),
        .r_i          (r_i),
        .g_i          (g_i),
        .b_i          (b_i),
        .pix_valid_o  (pix_valid_o),
        .pix_ready_i  (pix_ready_i),
        .pix_rgb_o    (pix_rgb_o),
        .pix_eol_o    (pix_eol_o),
        .pix_col_o    (pix_col_o),
        .pix_row_o    (pix_row_o),
        .row_end_o    (row_end_o),
        .frame_done_o (frame_done_o),
        .err_ovf_o    (err_ovf_o),
        .err_sync_o   (err_sync_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [2:0] v, input logic [2:0] nr,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        valid_i = v;
        nr_i    = nr;
        r_i     = r;
        g_i     = g;
        b_i     = b;
        tick();
        valid_i = 3'b000;
        nr_i    = 3'b000;
    endtask

    task automatic expect_pix(input logic [23:0] rgb, input logic eol);
        logic [11:0] c, rw;
        c  = mcol[11:0];
        rw = mrow[11:0];
        sbq.push_back({rgb, eol, c, rw});
        if (eol) begin
            mcol = 0;
            mrow++;
        end else begin
            mcol++;
        end
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while (sbq.size() != 0 && n < lim) begin
            tick();
            n++;
        end
        chk("drain_timeout", sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && row_end_o) re_cnt++;
        if (!rst && pix_valid_o && pix_ready_i) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pixel", pix_rgb_o, 0);
            end else begin
                logic [48:0] e;
                e = sbq.pop_front();
                chk("pix_rgb", pix_rgb_o, e[48:25]);
                chk("pix_eol", pix_eol_o, e[24]);
                chk("pix_col", pix_col_o, e[23:12]);
                chk("pix_row", pix_row_o, e[11:0]);
            end
        end
    end

    initial begin
        int prev;
        int n;
        rst = 1'b1;
        valid_i = 0; nr_i = 0; done_i = 0; r_i = 0; g_i = 0; b_i = 0;
        pix_ready_i = 1'b1;
        repeat (3) tick();
        chk("rst_pix_valid", pix_valid_o, 0);
        chk("rst_pix_rgb", pix_rgb_o, 0);
        chk("rst_flags", {row_end_o, frame_done_o, err_ovf_o, err_sync_o, pix_eol_o}, 0);
        chk("rst_pos", {pix_col_o, pix_row_o}, 0);
        rst = 1'b0;
        tick();

        // Row of 4 aligned pixels, NR with the 4th.
        for (int i = 1; i <= 4; i++) begin
            expect_pix({8'(i), 8'(10 + i), 8'(20 + i)}, i == 4);
            drv(3'b111, (i == 4) ? 3'b111 : 3'b000, 8'(i), 8'(10 + i), 8'(20 + i));
        end
        drain(20);

        // G lags R/B by 5 cycles.
        expect_pix({8'd31, 8'd41, 8'd51}, 1'b0);
        expect_pix({8'd32, 8'd42, 8'd52}, 1'b0);
        drv(3'b101, 3'b000, 8'd31, 8'd0, 8'd51);
        drv(3'b101, 3'b000, 8'd32, 8'd0, 8'd52);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("lag_no_valid", pix_valid_o, 0);
        end
        drv(3'b010, 3'b000, 8'd0, 8'd41, 8'd0);
        drv(3'b010, 3'b000, 8'd0, 8'd42, 8'd0);
        drain(20);
        chk("lag_err_sync", err_sync_o, 0);

        // Backpressure: output register + 16 FIFO entries, the 18th sample overflows.
        pix_ready_i = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            if (i <= 17) expect_pix({8'(i), 8'(i + 100), 8'(i + 200)}, 1'b0);
            drv(3'b111, 3'b000, 8'(i), 8'(i + 100), 8'(i + 200));
            if (i == 17) chk("ovf_before", err_ovf_o, 0);
        end
        chk("ovf_after", err_ovf_o, 1);
        chk("ovf_hold_valid", pix_valid_o, 1);
        pix_ready_i = 1'b1;
        drain(60);

        // Two pixels, stand-alone NR marker, then next row starts at col 0.
        prev = re_cnt;
        expect_pix({8'd61, 8'd71, 8'd81}, 1'b0);
        drv(3'b111, 3'b000, 8'd61, 8'd71, 8'd81);
        expect_pix({8'd62, 8'd72, 8'd82}, 1'b0);
        drv(3'b111, 3'b000, 8'd62, 8'd72, 8'd82);
        drv(3'b000, 3'b111, 8'd0, 8'd0, 8'd0);
        mcol = 0;
        mrow++;
        expect_pix({8'd63, 8'd73, 8'd83}, 1'b0);
        drv(3'b111, 3'b000, 8'd63, 8'd73, 8'd83);
        drain(20);
        chk("row_end_count", re_cnt - prev, 1);
        chk("row_end_idle", row_end_o, 0);

        // NR with the pixel on R only: desync, pixel emitted without eol.
        expect_pix({8'd90, 8'd91, 8'd92}, 1'b0);
        drv(3'b111, 3'b001, 8'd90, 8'd91, 8'd92);
        drain(20);
        chk("desync_err", err_sync_o, 1);
        drv(3'b000, 3'b111, 8'd0, 8'd0, 8'd0);
        mcol = 0;
        mrow++;
        tick();

        // End of frame.
        chk("frame_done_early", frame_done_o, 0);
        done_i = 3'b111;
        tick();
        done_i = 3'b000;
        n = 0;
        while (!frame_done_o && n < 20) begin
            tick();
            n++;
        end
        chk("frame_done", frame_done_o, 1);
        expect_pix({8'd5, 8'd6, 8'd7}, 1'b0);
        drv(3'b111, 3'b000, 8'd5, 8'd6, 8'd7);
        drain(20);
        chk("frame_done_sticky", frame_done_o, 1);

        // Reset mid second frame with data in flight.
        pix_ready_i = 1'b0;
        drv(3'b111, 3'b000, 8'd200, 8'd201, 8'd202);
        drv(3'b111, 3'b000, 8'd203, 8'd204, 8'd205);
        drv(3'b111, 3'b000, 8'd206, 8'd207, 8'd208);
        chk("inflight_valid", pix_valid_o, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_pix_valid", pix_valid_o, 0);
        chk("arst_pix_rgb", pix_rgb_o, 0);
        chk("arst_pos", {pix_col_o, pix_row_o}, 0);
        chk("arst_flags", {row_end_o, frame_done_o, err_ovf_o, err_sync_o, pix_eol_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        mcol = 0;
        mrow = 0;
        pix_ready_i = 1'b1;
        tick();
        expect_pix({8'd1, 8'd2, 8'd3}, 1'b0);
        drv(3'b111, 3'b000, 8'd1, 8'd2, 8'd3);
        drain(20);
        tick();
        chk("post_rst_idle", pix_valid_o, 0);
        chk("post_rst_errs", {err_ovf_o, err_sync_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
